// File: rtl/serial_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_out_pkg
//  Description : Shared types and line-level constants for the serial output
//                arbiter (FSM state encoding, start/stop/idle levels).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_out_pkg;

    // Frame sequencer states; PARITY is only reachable when parity is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width helper: never returns zero so single-value counters still exist.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin winner search starting at an internal priority
//                pointer. The pointer moves one past the winner on accept, so
//                the requester just served drops to lowest priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N_REQ-1:0] valid_i,
    input  logic             accept_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] index_o,
    output logic             any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    int               cand;
    logic             w_found;

    // First valid requester at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        grant_o = '0;
        index_o = '0;
        w_found = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!w_found && valid_i[cand[IDX_W-1:0]]) begin
                w_found                  = 1'b1;
                grant_o[cand[IDX_W-1:0]] = 1'b1;
                index_o                  = cand[IDX_W-1:0];
            end
        end
        any_o = w_found;
    end

    // Next pointer: one past the accepted winner, wrapping at N_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (index_o == IDX_W'(N_REQ - 1)) ? '0 : index_o + 1'b1;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : serial_out_arbiter
//  Description : Shares one serial pin between N_REQ byte producers. A
//                round-robin arbiter accepts one valid/ready request while
//                idle and the byte is sent as start, DATA_W bits LSB first,
//                (optional even parity), stop; each bit lasts CLKS_PER_BIT.
//                Optional parity bit: define SERIAL_OUT_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_out_arbiter
    import serial_out_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int DIV_W = clog2_min1(CLKS_PER_BIT);
    localparam int BIT_W = clog2_min1(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  gid_q, gid_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
`ifdef SERIAL_OUT_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_index;
    logic              w_any;
    logic              w_accept;
    logic              w_div_last;
    logic [DATA_W-1:0] w_sel_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk      (clk),
        .nrst     (nrst),
        .valid_i  (req_valid),
        .accept_i (w_accept),
        .grant_o  (w_grant),
        .index_o  (w_index),
        .any_o    (w_any)
    );

    // Requests are only ever accepted from IDLE; ready is masked elsewhere.
    assign w_accept   = (state_q == IDLE) && w_any;
    assign req_ready  = (state_q == IDLE) ? w_grant : '0;
    assign w_div_last = (div_q == DIV_LAST);

    // Select the winner's payload slice for capture.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_index == IDX_W'(i)) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Frame sequencer: next state, next line level and counter updates.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        busy_d   = busy_q;
        gid_d    = gid_q;
        shift_d  = shift_q;
        div_d    = div_q;
        bit_d    = bit_q;
`ifdef SERIAL_OUT_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                out_d  = IDLE_LEVEL;
                busy_d = 1'b0;
                div_d  = '0;
                bit_d  = '0;
                if (w_accept) begin
                    state_d  = START;
                    busy_d   = 1'b1;
                    out_d    = START_BIT;
                    gid_d    = w_index;
                    shift_d  = w_sel_data;
`ifdef SERIAL_OUT_PARITY_EN
                    parity_d = ^w_sel_data;
`endif
                end
            end
            START: begin
                if (w_div_last) begin
                    div_d   = '0;
                    state_d = DATA;
                    out_d   = shift_q[0];
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DATA: begin
                if (w_div_last) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef SERIAL_OUT_PARITY_EN
                        state_d = PARITY;
                        out_d   = parity_q;
`else
                        state_d = STOP;
                        out_d   = STOP_BIT;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                        out_d = shift_d[0];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`ifdef SERIAL_OUT_PARITY_EN
            PARITY: begin
                if (w_div_last) begin
                    div_d   = '0;
                    state_d = STOP;
                    out_d   = STOP_BIT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_div_last) begin
                    div_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    out_d   = IDLE_LEVEL;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = IDLE_LEVEL;
                busy_d  = 1'b0;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            out_q    <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            gid_q    <= '0;
            shift_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
`ifdef SERIAL_OUT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            gid_q    <= gid_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
`ifdef SERIAL_OUT_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_out_arbiter
//  Description : Directed bench for serial_out_arbiter: one instance with
//                CLKS_PER_BIT=4 and one with CLKS_PER_BIT=1 on a shared reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_out_arbiter;

`ifdef SERIAL_OUT_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    wire  [3:0]  req_ready;
    wire         out;
    wire         busy;
    wire  [1:0]  grant_id;

    logic [3:0]  req_valid_b = '0;
    logic [31:0] req_data_b = '0;
    wire  [3:0]  req_ready_b;
    wire         out_b;
    wire         busy_b;
    wire  [1:0]  grant_id_b;

    int checks = 0;
    int errors = 0;

    logic       out_rec  [0:63];
    logic       busy_rec [0:63];
    logic [3:0] ready_or;

    always #5 clk = ~clk;

    serial_out_arbiter #(.N_REQ(4), .DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out       (out),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    serial_out_arbiter #(.N_REQ(4), .DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid_b),
        .req_data  (req_data_b),
        .req_ready (req_ready_b),
        .out       (out_b),
        .busy      (busy_b),
        .grant_id  (grant_id_b)
    );

    // Expected line level for frame bit b of payload d.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef SERIAL_OUT_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic do_reset(input logic [3:0] valid_during);
        nrst      = 1'b0;
        req_valid = valid_during;
        req_valid_b = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        ready_or = '0;
    endtask

    task automatic wait_ready(input bit fast, output bit found, output int idx, output int waited);
        logic [3:0] r;
        found = 1'b0; idx = 0; waited = 200;
        #1;
        for (int w = 0; w < 200; w++) begin
            r = fast ? req_ready_b : req_ready;
            if (r != 4'b0) begin
                found = 1'b1; waited = w;
                for (int i = 0; i < 4; i++) if (r[i]) idx = i;
                ready_or = ready_or | r;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic record_frame(input bit fast, input int n);
        for (int c = 0; c < n; c++) begin
            out_rec[c]  = fast ? out_b : out;
            busy_rec[c] = fast ? busy_b : busy;
            ready_or    = ready_or | (fast ? req_ready_b : req_ready);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0; req_valid = '0; req_valid_b = '0;
        repeat (2) @(negedge clk);
        checks++; if (out !== 1'b1) begin errors++; $display("FAIL reset_out got %b want 1", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d want 0", grant_id); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (out_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b got out=%b busy=%b want 1/0", out_b, busy_b); end
        nrst = 1'b1;
    endtask

    task automatic test_single;
        bit found; int idx, waited, bad_bits, bad_busy;
        logic [8:0] hand;
        hand = 9'b101001010;
        do_reset(4'b0000);
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        wait_ready(1'b0, found, idx, waited);
        checks++; if (!found || idx != 0 || req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got ready=%b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_ready_pulse got %b want 0000", req_ready); end
        record_frame(1'b0, FRAME_CYC);
        bad_bits = 0; bad_busy = 0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (out_rec[c] !== exp_bit(8'hA5, c / 4)) bad_bits++;
            if (c / 4 < 9 && out_rec[c] !== hand[c / 4]) bad_bits++;
            if (busy_rec[c] !== 1'b1) bad_busy++;
        end
        checks++; if (bad_bits != 0) begin errors++; $display("FAIL single_bits got %0d wrong samples want 0", bad_bits); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL single_busy got %0d low samples want 0", bad_busy); end
        checks++; if (busy !== 1'b0 || out !== 1'b1) begin errors++; $display("FAIL single_end got busy=%b out=%b want 0/1", busy, out); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_gid got %0d want 0", grant_id); end
        checks++; if (ready_or !== 4'b0001) begin errors++; $display("FAIL single_ready_seen got %b want 0001", ready_or); end
    endtask

    task automatic test_fairness;
        bit found; int idx, waited, bad;
        logic [7:0] d;
        req_data = 32'h4433_2211;
        do_reset(4'b1111);
        for (int f = 0; f < 6; f++) begin
            wait_ready(1'b0, found, idx, waited);
            checks++; if (!found || idx != f % 4) begin errors++; $display("FAIL fair_order[%0d] got %0d want %0d", f, idx, f % 4); end
            if (f > 0) begin
                checks++; if (waited != 0) begin errors++; $display("FAIL fair_gap[%0d] got %0d extra idle cycles want 0", f, waited); end
            end
            d = req_data[idx*8 +: 8];
            @(negedge clk);
            record_frame(1'b0, FRAME_CYC);
            bad = 0;
            for (int c = 0; c < FRAME_CYC; c++)
                if (out_rec[c] !== exp_bit(d, c / 4) || busy_rec[c] !== 1'b1) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL fair_frame[%0d] got %0d wrong samples want 0", f, bad); end
            checks++; if (busy !== 1'b0 || out !== 1'b1 || grant_id !== 2'(f % 4)) begin
                errors++; $display("FAIL fair_idle[%0d] got busy=%b out=%b gid=%0d want 0/1/%0d", f, busy, out, grant_id, f % 4); end
        end
        req_valid = 4'b0;
    endtask

    task automatic test_wrap;
        bit found; int idx, waited;
        int exp_g [4] = '{1, 3, 1, 3};
        do_reset(4'b1010);
        for (int f = 0; f < 4; f++) begin
            wait_ready(1'b0, found, idx, waited);
            checks++; if (!found || idx != exp_g[f]) begin errors++; $display("FAIL wrap_order[%0d] got %0d want %0d", f, idx, exp_g[f]); end
            @(negedge clk);
            record_frame(1'b0, FRAME_CYC);
        end
        checks++; if ((ready_or & 4'b0101) !== 4'b0) begin errors++; $display("FAIL wrap_unused_ready got %b want 0000", ready_or & 4'b0101); end
        req_valid = 4'b0;
    endtask

    task automatic test_reset_mid;
        bit found; int idx, waited;
        do_reset(4'b0000);
        req_data[23:16] = 8'hC3;
        req_valid = 4'b0100;
        wait_ready(1'b0, found, idx, waited);
        checks++; if (!found || idx != 2) begin errors++; $display("FAIL mid_first_grant got %0d want 2", idx); end
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (17) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_inflight got busy=%b want 1", busy); end
        nrst = 1'b0;
        @(negedge clk);
        checks++; if (out !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++; $display("FAIL mid_reset got out=%b busy=%b gid=%0d want 1/0/0", out, busy, grant_id); end
        nrst = 1'b1;
        req_valid = 4'b1111;
        wait_ready(1'b0, found, idx, waited);
        checks++; if (!found || idx != 0 || waited != 0) begin errors++; $display("FAIL mid_next_grant got %0d want 0", idx); end
        @(negedge clk);
        req_valid = 4'b0000;
        record_frame(1'b0, FRAME_CYC);
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_gid got %0d want 0", grant_id); end
    endtask

    task automatic test_back_to_back;
        bit found; int idx, waited, bad;
        do_reset(4'b0000);
        req_data_b[23:16] = 8'h00;
        req_valid_b = 4'b0100;
        wait_ready(1'b1, found, idx, waited);
        checks++; if (!found || idx != 2) begin errors++; $display("FAIL b2b_grant1 got %0d want 2", idx); end
        @(negedge clk);
        req_data_b[23:16] = 8'hFF;
        record_frame(1'b1, FRAME_BITS);
        bad = 0;
        for (int c = 0; c < FRAME_BITS; c++)
            if (out_rec[c] !== exp_bit(8'h00, c) || busy_rec[c] !== 1'b1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frame1 got %0d wrong samples want 0", bad); end
        checks++; if (busy_b !== 1'b0 || out_b !== 1'b1) begin errors++; $display("FAIL b2b_gap got busy=%b out=%b want 0/1", busy_b, out_b); end
        wait_ready(1'b1, found, idx, waited);
        checks++; if (!found || idx != 2 || waited != 0) begin errors++; $display("FAIL b2b_grant2 got idx=%0d wait=%0d want 2/0", idx, waited); end
        @(negedge clk);
        req_valid_b = 4'b0000;
        record_frame(1'b1, FRAME_BITS);
        bad = 0;
        for (int c = 0; c < FRAME_BITS; c++)
            if (out_rec[c] !== exp_bit(8'hFF, c) || busy_rec[c] !== 1'b1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frame2 got %0d wrong samples want 0", bad); end
        bad = 0;
        for (int c = 1; c <= 8; c++) if (out_rec[c] !== 1'b1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ones got %0d zero data bits want 0", bad); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL b2b_end got busy=%b want 0", busy_b); end
    endtask

`ifdef SERIAL_OUT_PARITY_EN
    task automatic test_parity;
        bit found; int idx, waited, bad;
        logic [7:0] pd [2] = '{8'hA5, 8'h07};
        logic       pe [2] = '{1'b0, 1'b1};
        do_reset(4'b0000);
        for (int f = 0; f < 2; f++) begin
            req_data[7:0] = pd[f];
            req_valid = 4'b0001;
            wait_ready(1'b0, found, idx, waited);
            @(negedge clk);
            req_valid = 4'b0000;
            record_frame(1'b0, 44);
            bad = 0;
            for (int c = 36; c < 40; c++) if (out_rec[c] !== pe[f]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL parity_bit[%0d] got %b want %b", f, out_rec[36], pe[f]); end
            bad = 0;
            for (int c = 0; c < 44; c++) if (busy_rec[c] !== 1'b1) bad++;
            checks++; if (bad != 0 || busy !== 1'b0) begin errors++; $display("FAIL parity_len[%0d] got %0d low busy, end busy=%b want 0/0", f, bad, busy); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_OUT_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
